telem_write_sched: RTL and testbench

Write scheduler for the 16-entry target telemetry register file. Up to N_REQ sensor channels post coordinate updates (target id, X, Y, Z, T). The block arbitrates between them round-robin and rejects out-of-order (stale) timestamps per target. It issues exactly one write per accepted update on the register file's enable / targetSelection / coordinate buses, and acknowledges each requester with an accept/reject status.

---
 rtl/telem_write_sched_if.sv | 38 +++
 rtl/telem_write_sched.sv | 138 +++++++++++++
 tb/tb_telem_write_sched.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/telem_write_sched_if.sv
// telem_write_sched_if: bundle between sensor channels, the telemetry write scheduler and the register file.
// Ports:
//   req, req_target, req_x/y/z/t  channel -> scheduler request and payload (channel i at [4i+3:4i] / [8i+7:8i])
//   ack, ack_ok                   scheduler -> channel one-cycle acknowledge with accept/reject status
//   wr_en, wr_target, wr_x/y/z/t  scheduler -> register file write bus
//   busy, valid_mask, reject_cnt  scheduler status
// Modports: master = sensor side, slave = scheduler.
interface telem_write_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_target;
    logic [8*N_REQ-1:0] req_x;
    logic [8*N_REQ-1:0] req_y;
    logic [8*N_REQ-1:0] req_z;
    logic [8*N_REQ-1:0] req_t;
    logic [N_REQ-1:0]   ack;
    logic               ack_ok;
    logic               wr_en;
    logic [3:0]         wr_target;
    logic [7:0]         wr_x;
    logic [7:0]         wr_y;
    logic [7:0]         wr_z;
    logic [7:0]         wr_t;
    logic               busy;
    logic [15:0]        valid_mask;
    logic [7:0]         reject_cnt;

    modport master (
        output req, req_target, req_x, req_y, req_z, req_t,
        input  ack, ack_ok, wr_en, wr_target, wr_x, wr_y, wr_z, wr_t, busy, valid_mask, reject_cnt
    );

    modport slave (
        input  req, req_target, req_x, req_y, req_z, req_t,
        output ack, ack_ok, wr_en, wr_target, wr_x, wr_y, wr_z, wr_t, busy, valid_mask, reject_cnt
    );
endinterface

// File: rtl/telem_write_sched.sv
// telem_write_sched: round-robin write scheduler for the 16-entry target telemetry register file.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  telem_write_sched_if.slave: channel requests/acks, register-file write bus, status
// Each granted update is checked against the last accepted timestamp of its target
// (mod-256 window of 1..127 ahead) and is either written once or rejected as stale.
module telem_write_sched #(
    parameter int N_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    telem_write_sched_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_rr;
    logic [IW-1:0]    r_gnt;
    logic [3:0]       r_tgt;
    logic [7:0]       r_x;
    logic [7:0]       r_y;
    logic [7:0]       r_z;
    logic [7:0]       r_t;
    logic [7:0]       r_shadow [16];
    logic [15:0]      r_valid;
    logic [7:0]       r_rej;
    logic [N_REQ-1:0] r_ack;
    logic             r_ack_ok;
    logic             r_wr_en;
    logic             r_busy;

    logic [IW-1:0]    w_gnt;
    logic [IW-1:0]    w_hi_idx;
    logic [IW-1:0]    w_lo_idx;
    logic             w_hi;
    logic             w_lo;
    logic [7:0]       w_diff;
    logic             w_accept;

    // Descending scan so the last hit is the lowest index: w_hi_idx is the lowest
    // requester above rr_ptr, w_lo_idx the lowest overall (used when the search wraps).
    always_comb begin
        w_hi     = 1'b0;
        w_lo     = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[IW'(i)]) begin
                if (IW'(i) > r_rr) begin
                    w_hi     = 1'b1;
                    w_hi_idx = IW'(i);
                end
                w_lo     = 1'b1;
                w_lo_idx = IW'(i);
            end
        end
        w_gnt = w_hi ? w_hi_idx : w_lo_idx;
    end

    // Modular distance from the last accepted timestamp; 1..127 counts as newer.
    assign w_diff   = r_t - r_shadow[r_tgt];
    assign w_accept = !r_valid[r_tgt] || (w_diff != 8'd0 && !w_diff[7]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr     <= IW'(N_REQ - 1);
            r_gnt    <= '0;
            r_tgt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_t      <= '0;
            r_valid  <= '0;
            r_rej    <= '0;
            r_ack    <= '0;
            r_ack_ok <= 1'b0;
            r_wr_en  <= 1'b0;
            r_busy   <= 1'b0;
            for (int k = 0; k < 16; k++) r_shadow[k] <= 8'd0;
        end else begin
            r_ack    <= '0;
            r_ack_ok <= 1'b0;
            r_wr_en  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_lo) begin
                        r_state <= CHECK;
                        r_busy  <= 1'b1;
                        r_gnt   <= w_gnt;
                        r_tgt   <= bus.req_target[{w_gnt, 2'b00} +: 4];
                        r_x     <= bus.req_x[{w_gnt, 3'b000} +: 8];
                        r_y     <= bus.req_y[{w_gnt, 3'b000} +: 8];
                        r_z     <= bus.req_z[{w_gnt, 3'b000} +: 8];
                        r_t     <= bus.req_t[{w_gnt, 3'b000} +: 8];
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        r_state <= WRITE;
                        r_wr_en <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_ack   <= N_REQ'(1) << r_gnt;
                        r_rej   <= r_rej + {7'd0, r_rej != 8'hFF};
                    end
                end
                WRITE: begin
                    r_state         <= DONE;
                    r_shadow[r_tgt] <= r_t;
                    r_valid[r_tgt]  <= 1'b1;
                    r_ack           <= N_REQ'(1) << r_gnt;
                    r_ack_ok        <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rr    <= r_gnt;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.ack_ok     = r_ack_ok;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_target  = r_tgt;
    assign bus.wr_x       = r_x;
    assign bus.wr_y       = r_y;
    assign bus.wr_z       = r_z;
    assign bus.wr_t       = r_t;
    assign bus.busy       = r_busy;
    assign bus.valid_mask = r_valid;
    assign bus.reject_cnt = r_rej;
endmodule

// File: tb/tb_telem_write_sched.sv
// tb_telem_write_sched: randomized and directed bench for telem_write_sched with a transaction-level model.
module tb_telem_write_sched;
    localparam int N  = 4;
    localparam int W4 = 4 * N;
    localparam int W8 = 8 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    telem_write_sched_if #(.N_REQ(N)) bus ();
    telem_write_sched #(.N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // channel agents
    bit         ch_req [N];
    logic [3:0] ct  [N];
    logic [7:0] cx  [N];
    logic [7:0] cy  [N];
    logic [7:0] cz  [N];
    logic [7:0] ctt [N];
    int         tseq [N];
    bit         cont = 1'b0;
    bit         rnd  = 1'b0;
    logic [N-1:0] seen_ack = '0;

    // observations of the DUT
    int   ack_cnt [N];
    int   ack_cyc [N];
    bit   last_ok [N];
    int   log_ch [$];
    int   log_cyc [$];
    int   wr_count = 0;
    int   last_wr_cyc = 0;
    logic [3:0] lw_tgt = '0;
    logic [7:0] lw_x = '0, lw_y = '0, lw_z = '0, lw_t = '0;

    // transaction-level model
    logic [7:0]  m_sh [16];
    logic [15:0] m_mask, mask_prev;
    int          m_cnt, cnt_prev, m_rr, m_next, g, lat, gch, md, pick, df;
    bit          acc;
    logic [3:0]  gtg;
    logic [7:0]  gx, gy, gz, gt;
    int          e_ack;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 16; k++) m_sh[k] = 8'd0;
        m_mask = '0; mask_prev = '0;
        m_cnt = 0; cnt_prev = 0;
        m_rr = N - 1; m_next = 0;
        g = -1000; lat = 3; gch = 0; acc = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rst) begin
                m_reset();
                seen_ack = '0;
                chk("rst_ack", 32'(bus.ack), 0);
                chk("rst_ack_ok", 32'(bus.ack_ok), 0);
                chk("rst_wr_en", 32'(bus.wr_en), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                chk("rst_mask", 32'(bus.valid_mask), 0);
                chk("rst_rej", 32'(bus.reject_cnt), 0);
                chk("rst_wr_bus", {bus.wr_target, bus.wr_x, bus.wr_y, bus.wr_z[3:0], bus.wr_t[7:4]}, 0);
            end else begin
                md    = cyc - g;
                e_ack = (md == lat) ? (1 << gch) : 0;
                chk("busy", 32'(bus.busy), 32'(md >= 1 && md <= lat));
                chk("wr_en", 32'(bus.wr_en), 32'(acc && md == 2));
                chk("ack", 32'(bus.ack), e_ack);
                chk("ack_ok", 32'(bus.ack_ok), 32'(acc && md == lat));
                chk("valid_mask", 32'(bus.valid_mask), 32'((md < 3) ? mask_prev : m_mask));
                chk("reject_cnt", 32'(bus.reject_cnt), (md < 2) ? cnt_prev : m_cnt);
                if (acc && md == 2) begin
                    chk("wr_target", 32'(bus.wr_target), 32'(gtg));
                    chk("wr_xyzt", {bus.wr_x, bus.wr_y, bus.wr_z, bus.wr_t}, {gx, gy, gz, gt});
                end
                if (bus.wr_en) begin
                    wr_count++;
                    last_wr_cyc = cyc;
                    lw_tgt = bus.wr_target; lw_x = bus.wr_x; lw_y = bus.wr_y; lw_z = bus.wr_z; lw_t = bus.wr_t;
                end
                for (int i = 0; i < N; i++) begin
                    if (bus.ack[i]) begin
                        ack_cnt[i]++;
                        ack_cyc[i] = cyc;
                        last_ok[i] = bus.ack_ok;
                        log_ch.push_back(i);
                        log_cyc.push_back(cyc);
                    end
                end
                seen_ack = bus.ack;
                if (cyc >= m_next) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++)
                        if (pick < 0 && ch_req[(m_rr + k) % N]) pick = (m_rr + k) % N;
                    if (pick >= 0) begin
                        gch = pick; gtg = ct[pick]; gx = cx[pick]; gy = cy[pick]; gz = cz[pick]; gt = ctt[pick];
                        df  = (int'(gt) - int'(m_sh[gtg]) + 256) % 256;
                        acc = !m_mask[gtg] || (df >= 1 && df <= 127);
                        mask_prev = m_mask;
                        cnt_prev  = m_cnt;
                        if (acc) begin
                            m_sh[gtg]   = gt;
                            m_mask[gtg] = 1'b1;
                            lat = 3;
                        end else begin
                            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                            lat = 2;
                        end
                        m_rr   = pick;
                        g      = cyc;
                        m_next = cyc + lat + 1;
                    end
                end
            end
        end
    end

    task automatic drive();
        logic [N-1:0]  r;
        logic [W4-1:0] tg;
        logic [W8-1:0] x, y, z, t;
        r = '0; tg = '0; x = '0; y = '0; z = '0; t = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r  = (r << 1) | N'(ch_req[i]);
            tg = (tg << 4) | W4'(ct[i]);
            x  = (x << 8) | W8'(cx[i]);
            y  = (y << 8) | W8'(cy[i]);
            z  = (z << 8) | W8'(cz[i]);
            t  = (t << 8) | W8'(ctt[i]);
        end
        bus.req = r; bus.req_target = tg; bus.req_x = x; bus.req_y = y; bus.req_z = z; bus.req_t = t;
    endtask

    task automatic cont_payload(input int i);
        tseq[i]++;
        ch_req[i] = 1'b1; ct[i] = 4'(8 + i); ctt[i] = 8'(tseq[i]);
        cx[i] = 8'($urandom); cy[i] = 8'($urandom); cz[i] = 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (seen_ack[i]) begin
                if (cont) cont_payload(i);
                else ch_req[i] = 1'b0;
            end
            if (rnd && !ch_req[i] && $urandom_range(0, 3) == 0) begin
                ch_req[i] = 1'b1; ct[i] = 4'($urandom_range(0, 3)); ctt[i] = 8'($urandom);
                cx[i] = 8'($urandom); cy[i] = 8'($urandom); cz[i] = 8'($urandom);
            end
        end
        drive();
    endtask

    task automatic post(input int c, input logic [3:0] tg, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z, input logic [7:0] t);
        ch_req[c] = 1'b1; ct[c] = tg; cx[c] = x; cy[c] = y; cz[c] = z; ctt[c] = t;
        drive();
    endtask

    task automatic wait_ack(input int c);
        int a0 = ack_cnt[c];
        int k = 0;
        while (ack_cnt[c] == a0 && k < 40) begin
            tick();
            k++;
        end
        chk("ack_arrived", 32'(ack_cnt[c] != a0), 1);
    endtask

    task automatic drain();
        int k = 0;
        bit any = 1'b1;
        while (any && k < 80) begin
            tick();
            k++;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= ch_req[i];
        end
        chk("drained", 32'(any), 0);
    endtask

    int n, s, w0, a0, k;

    initial begin
        for (int i = 0; i < N; i++) begin
            ch_req[i] = 1'b0; ct[i] = '0; cx[i] = '0; cy[i] = '0; cz[i] = '0; ctt[i] = '0;
            tseq[i] = 0; ack_cnt[i] = 0; ack_cyc[i] = 0; last_ok[i] = 1'b0;
        end
        m_reset();
        drive();
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_mask", 32'(bus.valid_mask), 0);
        chk("reset_wr", {bus.wr_en, bus.wr_target, bus.wr_x, bus.wr_y, bus.wr_t[2:0]}, 0);
        rst = 1'b0;

        // single accepted update
        post(1, 4'd5, 8'h11, 8'h22, 8'h33, 8'd10);
        n = cyc;
        wait_ack(1);
        chk("t1_wr_latency", last_wr_cyc - n, 2);
        chk("t1_ack_latency", ack_cyc[1] - n, 3);
        chk("t1_wr_target", 32'(lw_tgt), 5);
        chk("t1_wr_xyzt", {lw_x, lw_y, lw_z, lw_t}, 32'h1122330A);
        chk("t1_ack_ok", 32'(last_ok[1]), 1);
        chk("t1_valid_mask", 32'(bus.valid_mask), 32'h0020);

        // equal and older timestamps are rejected
        w0 = wr_count;
        post(0, 4'd5, 8'h01, 8'h02, 8'h03, 8'd10);
        n = cyc;
        wait_ack(0);
        chk("t2_rej_latency", ack_cyc[0] - n, 2);
        chk("t2_equal_ok", 32'(last_ok[0]), 0);
        post(0, 4'd5, 8'h01, 8'h02, 8'h03, 8'd9);
        wait_ack(0);
        chk("t2_older_ok", 32'(last_ok[0]), 0);
        chk("t2_no_write", wr_count, w0);
        chk("t2_reject_cnt", 32'(bus.reject_cnt), 2);

        // timestamp wrap
        post(2, 4'd7, 8'h00, 8'h00, 8'h00, 8'd250);
        wait_ack(2);
        chk("t3_first_ok", 32'(last_ok[2]), 1);
        post(2, 4'd7, 8'h00, 8'h00, 8'h00, 8'd3);
        wait_ack(2);
        chk("t3_wrap_ok", 32'(last_ok[2]), 1);
        chk("t3_wrap_wr_t", 32'(lw_t), 3);
        post(2, 4'd7, 8'h00, 8'h00, 8'h00, 8'd200);
        wait_ack(2);
        chk("t3_back_ok", 32'(last_ok[2]), 0);
        chk("t3_reject_cnt", 32'(bus.reject_cnt), 3);

        // round-robin fairness, pointer parked on channel 3 first
        post(3, 4'd12, 8'h00, 8'h00, 8'h00, 8'd1);
        wait_ack(3);
        s = log_ch.size();
        cont = 1'b1;
        for (int i = 0; i < N; i++) cont_payload(i);
        drive();
        k = 0;
        while (log_ch.size() < s + 5 && k < 60) begin
            tick();
            k++;
        end
        chk("t4_ack_count", 32'(log_ch.size() >= s + 5), 1);
        for (int j = 0; j < 5; j++) chk("t4_rr_order", log_ch[s + j], j % N);
        for (int j = 1; j < 5; j++) chk("t4_ack_spacing", log_cyc[s + j] - log_cyc[s + j - 1], 4);
        cont = 1'b0;
        drain();

        // same target from two channels in one cycle
        post(1, 4'd13, 8'h00, 8'h00, 8'h00, 8'd1);
        wait_ack(1);
        s = log_ch.size();
        ch_req[2] = 1'b1; ct[2] = 4'd0; ctt[2] = 8'd40;
        ch_req[3] = 1'b1; ct[3] = 4'd0; ctt[3] = 8'd41;
        drive();
        wait_ack(3);
        chk("t5_first", log_ch[s], 2);
        chk("t5_second", log_ch[s + 1], 3);
        chk("t5_second_ok", 32'(last_ok[3]), 1);
        chk("t5_final_t", {24'd0, lw_t}, 41);
        chk("t5_final_tgt", 32'(lw_tgt), 0);

        // asynchronous reset in WRITE
        a0 = ack_cnt[2];
        post(2, 4'd14, 8'hA1, 8'hA2, 8'hA3, 8'd5);
        k = 0;
        while (!bus.wr_en && k < 10) begin
            tick();
            k++;
        end
        chk("t6_reached_write", 32'(bus.wr_en), 1);
        rst = 1'b1;
        #1;
        chk("t6_async_wr_en", 32'(bus.wr_en), 0);
        chk("t6_async_busy", 32'(bus.busy), 0);
        chk("t6_async_mask", 32'(bus.valid_mask), 0);
        chk("t6_async_rej", 32'(bus.reject_cnt), 0);
        chk("t6_async_tgt", 32'(bus.wr_target), 0);
        repeat (2) tick();
        rst = 1'b0;
        n = cyc;
        wait_ack(2);
        chk("t6_wr_latency", last_wr_cyc - n, 2);
        chk("t6_ack_latency", ack_cyc[2] - n, 3);
        chk("t6_single_ack", ack_cnt[2] - a0, 1);
        chk("t6_valid_mask", 32'(bus.valid_mask), 32'h4000);

        // randomized traffic
        rnd = 1'b1;
        repeat (1500) tick();
        rnd = 1'b0;
        drain();

        // saturation of the reject counter
        for (int j = 0; j < 300; j++) begin
            post(j % N, 4'd14, 8'h00, 8'h00, 8'h00, 8'd5);
            wait_ack(j % N);
        end
        chk("t7_saturated", 32'(bus.reject_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
